// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner scheduler for a shared 16:1 select mux.
// Holds one owner until it releases or its burst budget expires while
// others wait, then hands over back-to-back in rotating priority order.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        handover
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

  state_t           state, state_n;
  logic [15:0]      gnt_n;
  logic [3:0]       sel_n;
  logic             busy_n;
  logic             handover_n;
  logic [3:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [15:0] owner_mask;
  logic        released;
  logic        expired;
  logic [15:0] cand;
  logic [4:0]  pick_r;

  // First set bit of v scanning p, p+1, ... wrapping mod 16; MSB flags a hit.
  function automatic logic [4:0] pick(input logic [15:0] v, input logic [3:0] p);
    logic [4:0] r;
    logic [3:0] idx;
    r = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = p + 4'(k);
      if (!r[4] && v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // End-condition detection and winner search for the current cycle.
  always_comb begin
    owner_mask = 16'b1 << sel;
    released   = ~|(req & owner_mask);
    expired    = (cnt == LAST) && (|(req & ~owner_mask));
    // The current owner is excluded while busy: on release its bit is already
    // clear, on expiry it must yield to the waiting requesters.
    cand       = (state == IDLE) ? req : (req & ~owner_mask);
    pick_r     = pick(cand, ptr);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    sel_n      = sel;
    busy_n     = busy;
    handover_n = 1'b0;
    ptr_n      = ptr;
    cnt_n      = cnt;
    case (state)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        if (pick_r[4]) begin
          state_n = BUSY;
          gnt_n   = 16'b1 << pick_r[3:0];
          sel_n   = pick_r[3:0];
          busy_n  = 1'b1;
          cnt_n   = '0;
          ptr_n   = pick_r[3:0] + 4'd1;
        end
      end
      BUSY: begin
        if (released || expired) begin
          if (pick_r[4]) begin
            gnt_n      = 16'b1 << pick_r[3:0];
            sel_n      = pick_r[3:0];
            cnt_n      = '0;
            ptr_n      = pick_r[3:0] + 4'd1;
            handover_n = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
          end
        end else begin
          // A lone owner at the budget limit simply starts a fresh burst.
          cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      handover <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
      handover <= handover_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with MAX_BURST=8.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic        handover;

  int unsigned n_cmp;
  int unsigned n_err;

  mux16_rr_arbiter #(.MAX_BURST(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .handover (handover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] eg, input logic [3:0] es,
                     input logic eb, input logic eh);
    n_cmp++;
    assert (gnt === eg) else begin
      n_err++;
      $error("FAIL %s gnt got=%h exp=%h", tag, gnt, eg);
    end
    n_cmp++;
    assert (sel === es) else begin
      n_err++;
      $error("FAIL %s sel got=%0d exp=%0d", tag, sel, es);
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_err++;
      $error("FAIL %s busy got=%b exp=%b", tag, busy, eb);
    end
    n_cmp++;
    assert (handover === eh) else begin
      n_err++;
      $error("FAIL %s handover got=%b exp=%b", tag, handover, eh);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    #3;
    chk("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    #9;
    rst_n = 1'b1;

    // single requester; ptr 0 -> 6
    tick();
    req = 16'h0020;
    tick();
    chk("single_grant", 16'h0020, 4'd5, 1'b1, 1'b0);
    req = 16'h0000;
    #1;
    chk("single_lag", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick();
    chk("single_drop", 16'h0000, 4'd5, 1'b0, 1'b0);

    // wrap priority: 14 (ptr 15), release with 0,3 waiting -> 0, 3, 14
    req = 16'h4000;
    tick();
    chk("wrap_14", 16'h4000, 4'd14, 1'b1, 1'b0);
    req = 16'h0009;
    tick();
    chk("wrap_0", 16'h0001, 4'd0, 1'b1, 1'b1);
    req = 16'h4008;
    tick();
    chk("wrap_3", 16'h0008, 4'd3, 1'b1, 1'b1);
    req = 16'h4000;
    tick();
    chk("wrap_14b", 16'h4000, 4'd14, 1'b1, 1'b1);
    req = 16'h0000;
    tick();
    chk("wrap_idle", 16'h0000, 4'd14, 1'b0, 1'b0);

    // rotation 0/15 from ptr 15: 15 first, 8 cycles each
    req = 16'h8001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rot_a15", 16'h8000, 4'd15, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rot_b0", 16'h0001, 4'd0, 1'b1, (i == 0));
    end
    tick();
    chk("rot_c15", 16'h8000, 4'd15, 1'b1, 1'b1);
    req = 16'h0000;
    tick();
    chk("rot_idle", 16'h0000, 4'd15, 1'b0, 1'b0);

    // late arrival waits for owner 2's full budget (ptr 0 -> 2 -> 3)
    req = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_own2", 16'h0004, 4'd2, 1'b1, 1'b0);
    end
    req = 16'h0014;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("late_hold2", 16'h0004, 4'd2, 1'b1, 1'b0);
    end
    tick();
    chk("late_to4", 16'h0010, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("late_hold4", 16'h0010, 4'd4, 1'b1, 1'b0);
    end
    tick();
    chk("late_back2", 16'h0004, 4'd2, 1'b1, 1'b1);

    // solo hold: owner 2 releases, 8 takes over and keeps it for 30 cycles
    req = 16'h0100;
    tick();
    chk("solo_grant", 16'h0100, 4'd8, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("solo_hold", 16'h0100, 4'd8, 1'b1, 1'b0);
    end

    // burst counter now at 6: one more cycle, then expiry hands to 9
    req = 16'hFFFF;
    tick();
    chk("full_keep8", 16'h0100, 4'd8, 1'b1, 1'b0);
    tick();
    chk("full_to9", 16'h0200, 4'd9, 1'b1, 1'b1);
    tick();
    chk("full_hold9", 16'h0200, 4'd9, 1'b1, 1'b0);

    // async reset mid-burst, no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ptr0", 16'h0001, 4'd0, 1'b1, 1'b0);
    req = 16'h0000;
    tick();
    chk("final_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
